// File: rtl/accumulator_bank_if.sv
// accumulator_bank_if: bundles the update-beat handshake, the adder operand/sum
// link, the read port and the clear/status signals of accumulator_bank.
// The bank connects through the slave modport; the driving side (stream
// source, adder and reader) connects through the master modport.
interface accumulator_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) ();

    // Update beat stream
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_load;

    // External adder link: operands out, sum (with carry) back in
    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    logic [DATA_WIDTH:0]   add_s;

    // Read port
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    // Clear control and status
    logic                  clear_all;
    logic                  busy;
    logic                  ovf;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_addr,
        input  in_data,
        input  in_load,
        output add_a,
        output add_b,
        input  add_s,
        input  rd_en,
        input  rd_addr,
        output rd_valid,
        output rd_data,
        input  clear_all,
        output busy,
        output ovf
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_addr,
        output in_data,
        output in_load,
        input  add_a,
        input  add_b,
        output add_s,
        output rd_en,
        output rd_addr,
        input  rd_valid,
        input  rd_data,
        output clear_all,
        input  busy,
        input  ovf
    );

endinterface

// File: rtl/accumulator_bank.sv
// accumulator_bank: DEPTH-entry pipelined accumulator memory feeding an
// external combinational adder. S1 holds the accepted beat and drives the
// adder operands, S2 holds the sum and writes it back. An S2->S1 bypass keeps
// back-to-back beats to one entry correct without stalling. A read port
// forwards from S1/S2/memory, and a clear sequence drains the pipe and then
// zeroes one entry per cycle.
module accumulator_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    accumulator_bank_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Control FSM
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_in_ready;
    logic                  w_enter_clear;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] r_cnt;

    // Entry storage
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      w_upd_we;
    logic [DEPTH-1:0]      w_clr_hit;

    // Stage S1: accepted beat
    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_load;

    // Stage S2: computed result awaiting write-back
    logic                  r_s2_valid;
    logic [ADDR_WIDTH-1:0] r_s2_addr;
    logic [DATA_WIDTH-1:0] r_s2_data;

    // Datapath helpers
    logic                  w_accept;
    logic                  w_s2_hit_s1;
    logic [DATA_WIDTH-1:0] w_s1_operand;
    logic [DATA_WIDTH-1:0] w_s1_result;
    logic [DATA_WIDTH-1:0] w_add_a;
    logic [DATA_WIDTH-1:0] w_add_b;

    // Read port and status
    logic                  w_rd_accept;
    logic [DATA_WIDTH-1:0] w_rd_value;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_ovf;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; a clear request blocks the beat of its own cycle
    always_comb begin
        w_state_next  = r_state;
        w_in_ready    = 1'b0;
        w_enter_clear = 1'b0;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = !bus.clear_all;
                if (bus.clear_all) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_s1_valid && !r_s2_valid) begin
                    w_state_next  = ST_CLEAR;
                    w_enter_clear = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Clear index counter; wraps back to 0 after the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_enter_clear) begin
            r_cnt <= '0;
        end else if (w_clr_we) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = (r_state != ST_IDLE);
    assign w_accept     = bus.in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------

    // S1 captures the beat at accept; invalid otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
            r_s1_load  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_addr <= bus.in_addr;
                r_s1_data <= bus.in_data;
                r_s1_load <= bus.in_load;
            end
        end
    end

    // Operand selection with S2 bypass; operands are forced to zero on an idle S1
    always_comb begin
        w_s2_hit_s1  = r_s2_valid && (r_s2_addr == r_s1_addr);
        w_s1_operand = w_s2_hit_s1 ? r_s2_data : r_mem[r_s1_addr];
        w_add_a      = '0;
        w_add_b      = '0;
        if (r_s1_valid) begin
            w_add_a = r_s1_load ? '0 : w_s1_operand;
            w_add_b = r_s1_data;
        end
        w_s1_result  = r_s1_load ? r_s1_data : bus.add_s[DATA_WIDTH-1:0];
    end

    assign bus.add_a = w_add_a;
    assign bus.add_b = w_add_b;

    // S2 holds the wrapped sum until it is written back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_data  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_s1_addr;
            r_s2_data  <= bus.add_s[DATA_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------

    // Per-entry write enables: S2 write-back and clear sweep
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
        assign w_upd_we[gi]  = r_s2_valid && (r_s2_addr == ADDR_WIDTH'(gi));
        assign w_clr_hit[gi] = w_clr_we && (r_cnt == ADDR_WIDTH'(gi));
    end

    // Entry registers; the clear sweep never overlaps a write-back since the pipe is drained first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clr_hit[i]) begin
                    r_mem[i] <= '0;
                end else if (w_upd_we[i]) begin
                    r_mem[i] <= r_s2_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------

    // Sticky carry-out of accumulates; cleared when the clear sweep starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_enter_clear) begin
            r_ovf <= 1'b0;
        end else if (r_s1_valid && !r_s1_load && bus.add_s[DATA_WIDTH]) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------

    assign w_rd_accept = bus.rd_en && (r_state == ST_IDLE);

    // Read forwarding: the newest in-flight value for the entry wins (S1, then S2, then storage)
    always_comb begin
        w_rd_value = r_mem[bus.rd_addr];
        if (r_s2_valid && (r_s2_addr == bus.rd_addr)) begin
            w_rd_value = r_s2_data;
        end
        if (r_s1_valid && (r_s1_addr == bus.rd_addr)) begin
            w_rd_value = w_s1_result;
        end
    end

    // Registered read result; rd_data holds its last value between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data <= w_rd_value;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;

endmodule
